// File: rtl/sky130_sram_1rw1r_param.sv
// 1RW + 1R SRAM behavioural model with a post-reset clear sequencer,
// busy flag, held read data with valid strobes and same-address collision flag.
//
// Ports:
//   clk0, rst0                 : clock, synchronous active-high reset
//   busy                       : high in reset and while the array is cleared
//   csb0, web0, wmask0,
//   spare_wen0, addr0, din0    : port 0 read/write request
//   dout0, dout0_valid         : port 0 read data and update strobe
//   csb1, addr1                : port 1 read request
//   dout1, dout1_valid         : port 1 read data and update strobe
//   collision                  : port 1 read hit the word port 0 wrote
module sky130_sram_1rw1r_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int WMASK_WIDTH    = 8,
  parameter int NUM_WMASKS     = DATA_WIDTH / WMASK_WIDTH,
  parameter int NUM_SPARE      = 1,
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                            clk0,
  input  logic                            rst0,
  output logic                            busy,
  input  logic                            csb0,
  input  logic                            web0,
  input  logic [NUM_WMASKS-1:0]           wmask0,
  input  logic [NUM_SPARE-1:0]            spare_wen0,
  input  logic [ADDR_WIDTH-1:0]           addr0,
  input  logic [DATA_WIDTH+NUM_SPARE-1:0] din0,
  output logic [DATA_WIDTH+NUM_SPARE-1:0] dout0,
  output logic                            dout0_valid,
  input  logic                            csb1,
  input  logic [ADDR_WIDTH-1:0]           addr1,
  output logic [DATA_WIDTH+NUM_SPARE-1:0] dout1,
  output logic                            dout1_valid,
  output logic                            collision
);

  localparam int W = DATA_WIDTH + NUM_SPARE;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  logic [W-1:0] mem [RAM_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic [W-1:0]          dout0_q, dout0_d;
  logic [W-1:0]          dout1_q, dout1_d;
  logic                  dout0_valid_q, dout0_valid_d;
  logic                  dout1_valid_q, dout1_valid_d;
  logic                  collision_q, collision_d;

  logic                  clr_last;
  logic                  clear_we;
  logic                  ready;
  logic                  p0_wr, p0_rd, p1_rd;
  logic                  coll;
  logic [W-1:0]          bit_mask;
  logic [W-1:0]          old0, old1, merged;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [W-1:0]          mem_wdata;

  assign clr_last = clr_cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1);

  // State register
  always_ff @(posedge clk0) begin
    state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (rst0) begin
      state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    end else if (state_q == ST_CLEAR && clr_last) begin
      state_d = ST_READY;
    end
  end

  // Outputs of the FSM: clear writes and busy
  always_comb begin
    clear_we  = (state_q == ST_CLEAR) && !rst0;
    clr_cnt_d = clr_cnt_q;
    if (clear_we) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
    end
    // busy drops one edge after the final clear write
    busy_d = rst0 || (state_q == ST_CLEAR);
  end

  // Access decode and write merge
  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      bit_mask[i*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{wmask0[i]}};
    end
    for (int j = 0; j < NUM_SPARE; j++) begin
      bit_mask[DATA_WIDTH+j] = spare_wen0[j];
    end
    ready  = !busy_q && !rst0;
    p0_wr  = ready && !csb0 && !web0;
    p0_rd  = ready && !csb0 && web0;
    p1_rd  = ready && !csb1;
    old0   = mem[addr0];
    old1   = mem[addr1];
    merged = (old0 & ~bit_mask) | (din0 & bit_mask);
    coll   = p0_wr && p1_rd && (addr0 == addr1) && (|bit_mask);
  end

  // Single array write port shared by the clear sequencer and port 0
  always_comb begin
    mem_we    = clear_we || p0_wr;
    mem_waddr = clear_we ? clr_cnt_q : addr0;
    mem_wdata = clear_we ? '0 : merged;
  end

  always_ff @(posedge clk0) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read data holds when the port is idle
  always_comb begin
    dout0_d       = p0_rd ? old0 : dout0_q;
    dout1_d       = dout1_q;
    if (p1_rd) begin
      dout1_d = (coll && WRITE_MODE == 1) ? merged : old1;
    end
    dout0_valid_d = p0_rd;
    dout1_valid_d = p1_rd;
    collision_d   = coll;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      clr_cnt_q     <= '0;
      busy_q        <= 1'b1;
      dout0_q       <= '0;
      dout1_q       <= '0;
      dout0_valid_q <= 1'b0;
      dout1_valid_q <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      clr_cnt_q     <= clr_cnt_d;
      busy_q        <= busy_d;
      dout0_q       <= dout0_d;
      dout1_q       <= dout1_d;
      dout0_valid_q <= dout0_valid_d;
      dout1_valid_q <= dout1_valid_d;
      collision_q   <= collision_d;
    end
  end

  assign busy        = busy_q;
  assign dout0       = dout0_q;
  assign dout1       = dout1_q;
  assign dout0_valid = dout0_valid_q;
  assign dout1_valid = dout1_valid_q;
  assign collision   = collision_q;

endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Bench for sky130_sram_1rw1r_param: directed vectors, clear/reset
// sequences and random traffic against an array model.
module tb_sky130_sram_1rw1r_param;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic        csb0, web0, csb1, sp;
  logic [3:0]  wm;
  logic [7:0]  a0, a1;
  logic [32:0] din;

  logic        busy_a, busy_b, busy_c;
  logic [32:0] d0_a, d1_a, d0_b, d1_b, d0_c, d1_c;
  logic        v0_a, v1_a, v0_b, v1_b, v0_c, v1_c;
  logic        col_a, col_b, col_c;

  int passed = 0;
  int total  = 0;

  logic [32:0] mdl [256];
  logic [32:0] e_d0, e_d1a, e_d1b;

  always #5 clk0 = ~clk0;

  sky130_sram_1rw1r_param #(.WRITE_MODE(0)) dut_a (
    .clk0(clk0), .rst0(rst0), .busy(busy_a),
    .csb0(csb0), .web0(web0), .wmask0(wm),
    .spare_wen0(sp), .addr0(a0), .din0(din),
    .dout0(d0_a), .dout0_valid(v0_a),
    .csb1(csb1), .addr1(a1),
    .dout1(d1_a), .dout1_valid(v1_a),
    .collision(col_a)
  );

  sky130_sram_1rw1r_param #(.WRITE_MODE(1)) dut_b (
    .clk0(clk0), .rst0(rst0), .busy(busy_b),
    .csb0(csb0), .web0(web0), .wmask0(wm),
    .spare_wen0(sp), .addr0(a0), .din0(din),
    .dout0(d0_b), .dout0_valid(v0_b),
    .csb1(csb1), .addr1(a1),
    .dout1(d1_b), .dout1_valid(v1_b),
    .collision(col_b)
  );

  sky130_sram_1rw1r_param #(.CLEAR_ON_RESET(0)) dut_c (
    .clk0(clk0), .rst0(rst0), .busy(busy_c),
    .csb0(csb0), .web0(web0), .wmask0(wm),
    .spare_wen0(sp), .addr0(a0), .din0(din),
    .dout0(d0_c), .dout0_valid(v0_c),
    .csb1(csb1), .addr1(a1),
    .dout1(d1_c), .dout1_valid(v1_c),
    .collision(col_c)
  );

  typedef struct {
    logic        csb0, web0;
    logic [3:0]  wm;
    logic        sp;
    logic [7:0]  a0;
    logic [32:0] din;
    logic        csb1;
    logic [7:0]  a1;
    logic [32:0] e_d0;
    logic        e_v0;
    logic [32:0] e_d1a, e_d1b;
    logic        e_v1, e_col;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wm = '0; sp = 1'b0;
    a0 = '0; din = '0; csb1 = 1'b1; a1 = '0;
  endtask

  function automatic logic [32:0] mrg(input logic [32:0] old,
                                      input logic [32:0] nd,
                                      input logic [3:0]  m,
                                      input logic        s);
    logic [32:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[i*8 +: 8] = nd[i*8 +: 8];
    if (s) r[32] = nd[32];
    return r;
  endfunction

  function automatic vec_t mk(
      input logic c0, input logic w0, input logic [3:0] m,
      input logic s, input logic [7:0] x0, input logic [32:0] d,
      input logic c1, input logic [7:0] x1,
      input logic [32:0] ed0, input logic ev0,
      input logic [32:0] ed1a, input logic [32:0] ed1b,
      input logic ev1, input logic ec);
    vec_t v;
    v.csb0 = c0; v.web0 = w0; v.wm = m; v.sp = s;
    v.a0 = x0; v.din = d; v.csb1 = c1; v.a1 = x1;
    v.e_d0 = ed0; v.e_v0 = ev0;
    v.e_d1a = ed1a; v.e_d1b = ed1b;
    v.e_v1 = ev1; v.e_col = ec;
    return v;
  endfunction

  // Counts edges after the first released edge until busy drops
  task automatic count_busy(input string nm);
    int n;
    step();
    chk({nm, "_busy_c_e0"}, busy_c, 1'b0);
    chk({nm, "_busy_e0"}, busy_a, 1'b1);
    n = 0;
    while (busy_a && n < 400) begin
      step();
      n++;
    end
    chk({nm, "_busy_len"}, n, 256);
  endtask

  initial begin
    idle();
    rst0 = 1'b1;
    for (int i = 0; i < 256; i++) mdl[i] = '0;

    repeat (3) step();
    chk("rst_busy", busy_a, 1'b1);
    chk("rst_dout0", d0_a, '0);
    chk("rst_dout1", d1_a, '0);
    chk("rst_v0", v0_a, 1'b0);
    chk("rst_v1", v1_a, 1'b0);
    chk("rst_col", col_a, 1'b0);

    rst0 = 1'b0;
    count_busy("clr1");

    tv[0]  = mk(1,1,4'h0,0,8'h00,33'h0,0,8'h00,
                33'h0,0,33'h0,33'h0,1,0);
    tv[1]  = mk(1,1,4'h0,0,8'h00,33'h0,0,8'h7F,
                33'h0,0,33'h0,33'h0,1,0);
    tv[2]  = mk(1,1,4'h0,0,8'h00,33'h0,0,8'hFF,
                33'h0,0,33'h0,33'h0,1,0);
    tv[3]  = mk(0,0,4'b0101,1,8'h10,33'h1DEADBEEF,1,8'h00,
                33'h0,0,33'h0,33'h0,0,0);
    tv[4]  = mk(0,1,4'h0,0,8'h10,33'h0,1,8'h00,
                33'h100AD00EF,1,33'h0,33'h0,0,0);
    tv[5]  = mk(1,1,4'h0,0,8'h00,33'h0,1,8'h00,
                33'h100AD00EF,0,33'h0,33'h0,0,0);
    tv[6]  = mk(0,0,4'hF,1,8'h20,33'h011111111,1,8'h00,
                33'h100AD00EF,0,33'h0,33'h0,0,0);
    tv[7]  = mk(0,0,4'hF,1,8'h20,33'h022222222,0,8'h20,
                33'h100AD00EF,0,33'h011111111,33'h022222222,1,1);
    tv[8]  = mk(0,1,4'h0,0,8'h20,33'h0,0,8'h20,
                33'h022222222,1,33'h022222222,33'h022222222,1,0);
    tv[9]  = mk(0,0,4'h0,0,8'h20,33'h133333333,0,8'h20,
                33'h022222222,0,33'h022222222,33'h022222222,1,0);
    tv[10] = mk(0,0,4'hF,1,8'h30,33'h00000ABCD,1,8'h00,
                33'h022222222,0,33'h022222222,33'h022222222,0,0);
    tv[11] = mk(0,1,4'h0,0,8'h30,33'h0,1,8'h00,
                33'h00000ABCD,1,33'h022222222,33'h022222222,0,0);

    for (int k = 0; k < 12; k++) begin
      csb0 = tv[k].csb0; web0 = tv[k].web0; wm = tv[k].wm;
      sp = tv[k].sp; a0 = tv[k].a0; din = tv[k].din;
      csb1 = tv[k].csb1; a1 = tv[k].a1;
      if (!csb0 && !web0) mdl[a0] = mrg(mdl[a0], din, wm, sp);
      step();
      chk($sformatf("tv%0d_d0", k), d0_a, tv[k].e_d0);
      chk($sformatf("tv%0d_d0b", k), d0_b, tv[k].e_d0);
      chk($sformatf("tv%0d_v0", k), v0_a, tv[k].e_v0);
      chk($sformatf("tv%0d_d1a", k), d1_a, tv[k].e_d1a);
      chk($sformatf("tv%0d_d1b", k), d1_b, tv[k].e_d1b);
      chk($sformatf("tv%0d_v1", k), v1_a, tv[k].e_v1);
      chk($sformatf("tv%0d_col", k), col_a, tv[k].e_col);
      chk($sformatf("tv%0d_colb", k), col_b, tv[k].e_col);
    end

    idle();
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("hold%0d_d0", k), d0_a, 33'h00000ABCD);
      chk($sformatf("hold%0d_v0", k), v0_a, 1'b0);
    end

    e_d0 = 33'h00000ABCD;
    e_d1a = 33'h022222222;
    e_d1b = 33'h022222222;
    for (int k = 0; k < 300; k++) begin
      logic [32:0] o0, o1, nw;
      logic wr, rd0, rd1, cl;
      csb0 = 1'($urandom_range(0, 3) == 0);
      web0 = 1'($urandom);
      wm   = 4'($urandom);
      sp   = 1'($urandom);
      a0   = 8'($urandom_range(0, 15));
      din  = {1'($urandom), 32'($urandom)};
      csb1 = 1'($urandom_range(0, 3) == 0);
      a1   = ($urandom_range(0, 1) == 0) ? a0
             : 8'($urandom_range(0, 15));
      o0  = mdl[a0];
      o1  = mdl[a1];
      nw  = mrg(o0, din, wm, sp);
      wr  = !csb0 && !web0;
      rd0 = !csb0 && web0;
      rd1 = !csb1;
      cl  = wr && rd1 && a0 == a1 && (wm != 0 || sp);
      if (rd0) e_d0 = o0;
      if (rd1) begin
        e_d1a = o1;
        e_d1b = cl ? nw : o1;
      end
      if (wr) mdl[a0] = nw;
      step();
      chk($sformatf("rnd%0d_d0", k), d0_a, e_d0);
      chk($sformatf("rnd%0d_v0", k), v0_a, rd0);
      chk($sformatf("rnd%0d_d1a", k), d1_a, e_d1a);
      chk($sformatf("rnd%0d_d1b", k), d1_b, e_d1b);
      chk($sformatf("rnd%0d_v1", k), v1_a, rd1);
      chk($sformatf("rnd%0d_col", k), col_a, cl);
      chk($sformatf("rnd%0d_colb", k), col_b, cl);
    end

    idle();
    rst0 = 1'b1;
    step();
    chk("rst2_busy", busy_a, 1'b1);
    chk("rst2_d0", d0_a, '0);
    chk("rst2_d1", d1_a, '0);
    chk("rst2_d1b", d1_b, '0);
    rst0 = 1'b0;
    step();
    for (int k = 1; k < 100; k++) begin
      if (k == 50) begin
        csb0 = 1'b0; web0 = 1'b0; wm = 4'hF; sp = 1'b1;
        a0 = 8'h05; din = 33'h1CAFEF00D;
        csb1 = 1'b0; a1 = 8'h05;
      end else begin
        idle();
      end
      step();
      if (k == 50) begin
        chk("busy_wr_v0", v0_a, 1'b0);
        chk("busy_wr_v1", v1_a, 1'b0);
        chk("busy_wr_col", col_a, 1'b0);
        chk("busy_d0_hold", d0_a, '0);
      end
    end
    idle();
    rst0 = 1'b1;
    step();
    chk("midclr_busy", busy_a, 1'b1);
    chk("midclr_d0", d0_a, '0);
    chk("midclr_d1", d1_a, '0);
    rst0 = 1'b0;
    count_busy("clr2");
    for (int i = 0; i < 256; i++) mdl[i] = '0;

    csb0 = 1'b0; web0 = 1'b1; a0 = 8'h05;
    csb1 = 1'b0; a1 = 8'h10;
    step();
    chk("post_d0", d0_a, mdl[5]);
    chk("post_v0", v0_a, 1'b1);
    chk("post_d1", d1_a, mdl[16]);
    chk("post_v1", v1_a, 1'b1);
    idle();
    step();
    chk("post_v0_off", v0_a, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
